// File: rtl/axi_arb_pkg.sv
// Shared encodings and defaults for the IF/MEM request arbiter.
package axi_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } arb_state_t;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_MEM  = 2'd2
  } arb_owner_t;

  // Consecutive MEM grants tolerated while IF waits before IF is forced through.
  localparam int unsigned MEM_STREAK_MAX_DEF = 4;
  // Width of the saturating MEM streak counter.
  localparam int unsigned STREAK_W = 3;

endpackage

// File: rtl/arb_req_slot.sv
// One pending-request slot: a pend flag plus the fields captured with the start pulse.
module arb_req_slot (
  input  logic        clk,
  input  logic        resetn,
  input  logic        capture,
  input  logic        clear,
  input  logic        flush,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wstrb,
  output logic        pend,
  output logic        slot_we,
  output logic [31:0] slot_addr,
  output logic [31:0] slot_wdata,
  output logic [3:0]  slot_wstrb
);

  // Pend flag: a fresh capture wins over a flush in the same cycle, since the
  // flush only targets requests that were already waiting.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      pend <= 1'b0;
    end else if (capture) begin
      pend <= 1'b1;
    end else if (clear || flush) begin
      pend <= 1'b0;
    end
  end

  // Captured fields are only meaningful while pend is set, so they carry no reset.
  always_ff @(posedge clk) begin
    if (capture) begin
      slot_we    <= req_we;
      slot_addr  <= req_addr;
      slot_wdata <= req_wdata;
      slot_wstrb <= req_wstrb;
    end
  end

endmodule

// File: rtl/axi_req_arbiter.sv
// Shares one AXI user-level master between instruction fetch (IF) and data
// memory (MEM). MEM has priority; IF is forced through after a streak of MEM grants.
module axi_req_arbiter
  import axi_arb_pkg::*;
#(
  parameter int unsigned MEM_STREAK_MAX = MEM_STREAK_MAX_DEF
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        if_start,
  input  logic [31:0] if_addr,
  input  logic        if_flush,
  output logic        if_busy,
  output logic        if_done,
  output logic [31:0] if_rdata,
  input  logic        mem_start,
  input  logic        mem_we,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic        mem_busy,
  output logic        mem_done,
  output logic [31:0] mem_rdata,
  output logic        m_start,
  output logic        m_we,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  output logic [3:0]  m_wstrb,
  input  logic        m_done,
  input  logic [31:0] m_rdata,
  input  logic        m_busy
);

  localparam logic [STREAK_W-1:0] STREAK_LIMIT = STREAK_W'(MEM_STREAK_MAX);

  arb_state_t          state;
  arb_state_t          state_nxt;
  arb_owner_t          owner;
  logic                discard;
  logic [STREAK_W-1:0] streak;

  logic        pend_if;
  logic        pend_mem;
  logic        slot_if_we;
  logic [31:0] slot_if_addr;
  logic [31:0] slot_if_wdata;
  logic [3:0]  slot_if_wstrb;
  logic        slot_mem_we;
  logic [31:0] slot_mem_addr;
  logic [31:0] slot_mem_wdata;
  logic [3:0]  slot_mem_wstrb;

  logic if_accept;
  logic mem_accept;
  logic pend_if_live;
  logic pick_if;
  logic grant_if;
  logic grant_mem;
  logic done_evt;
  logic done_if;
  logic done_mem;

  assign if_busy      = pend_if | (owner == OWN_IF);
  assign mem_busy     = pend_mem | (owner == OWN_MEM);
  assign if_accept    = if_start & ~if_busy;
  assign mem_accept   = mem_start & ~mem_busy;
  // A flush arriving in the grant cycle must keep the stale fetch off the bus.
  assign pend_if_live = pend_if & ~if_flush;
  assign pick_if      = pend_if_live & (~pend_mem | (streak == STREAK_LIMIT));
  assign m_start      = (state == ST_ISSUE);
  assign done_evt     = (state == ST_WAIT) & m_done;
  assign done_if      = done_evt & (owner == OWN_IF) & ~discard;
  assign done_mem     = done_evt & (owner == OWN_MEM);

  arb_req_slot u_slot_if (
    .clk        (clk),
    .resetn     (resetn),
    .capture    (if_accept),
    .clear      (grant_if),
    .flush      (if_flush),
    .req_we     (1'b0),
    .req_addr   (if_addr),
    .req_wdata  (32'h0),
    .req_wstrb  (4'h0),
    .pend       (pend_if),
    .slot_we    (slot_if_we),
    .slot_addr  (slot_if_addr),
    .slot_wdata (slot_if_wdata),
    .slot_wstrb (slot_if_wstrb)
  );

  arb_req_slot u_slot_mem (
    .clk        (clk),
    .resetn     (resetn),
    .capture    (mem_accept),
    .clear      (grant_mem),
    .flush      (1'b0),
    .req_we     (mem_we),
    .req_addr   (mem_addr),
    .req_wdata  (mem_wdata),
    .req_wstrb  (mem_wstrb),
    .pend       (pend_mem),
    .slot_we    (slot_mem_we),
    .slot_addr  (slot_mem_addr),
    .slot_wdata (slot_mem_wdata),
    .slot_wstrb (slot_mem_wstrb)
  );

  // State register for the IDLE/ISSUE/WAIT sequencer.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and grant decision; a grant is only taken in IDLE with the master free.
  always_comb begin
    state_nxt = state;
    grant_if  = 1'b0;
    grant_mem = 1'b0;
    case (state)
      ST_IDLE: begin
        if ((pend_if_live | pend_mem) & ~m_busy) begin
          grant_if  = pick_if;
          grant_mem = ~pick_if;
          state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE: state_nxt = ST_WAIT;
      ST_WAIT: begin
        if (m_done) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Ownership of the in-flight transaction and the discard mark for flushed fetches.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      owner   <= OWN_NONE;
      discard <= 1'b0;
    end else begin
      if (grant_if) begin
        owner <= OWN_IF;
      end else if (grant_mem) begin
        owner <= OWN_MEM;
      end else if (done_evt) begin
        owner <= OWN_NONE;
      end
      if (done_evt) begin
        discard <= 1'b0;
      end else if (if_flush && (owner == OWN_IF)) begin
        discard <= 1'b1;
      end
    end
  end

  // Saturating count of MEM grants taken while IF was left waiting.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      streak <= '0;
    end else if (grant_if || !pend_if) begin
      streak <= '0;
    end else if (grant_mem && (streak != '1)) begin
      streak <= streak + 1'b1;
    end
  end

  // Transaction fields are loaded at grant and held until the next grant.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      m_we    <= 1'b0;
      m_addr  <= '0;
      m_wdata <= '0;
      m_wstrb <= '0;
    end else if (grant_if) begin
      m_we    <= slot_if_we;
      m_addr  <= slot_if_addr;
      m_wdata <= slot_if_wdata;
      m_wstrb <= slot_if_wstrb;
    end else if (grant_mem) begin
      m_we    <= slot_mem_we;
      m_addr  <= slot_mem_addr;
      m_wdata <= slot_mem_wdata;
      m_wstrb <= slot_mem_wstrb;
    end
  end

  // Completion routing: done pulse and read data go only to the owner.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      if_done   <= 1'b0;
      mem_done  <= 1'b0;
      if_rdata  <= '0;
      mem_rdata <= '0;
    end else begin
      if_done  <= done_if;
      mem_done <= done_mem;
      if (done_if) begin
        if_rdata <= m_rdata;
      end
      if (done_mem) begin
        mem_rdata <= m_rdata;
      end
    end
  end

endmodule

// File: tb/tb_axi_req_arbiter.sv
// Bench for axi_req_arbiter: directed vector table, multi-cycle corner
// sequences, then randomized traffic against a transaction-level model.
module tb_axi_req_arbiter;

  localparam int STREAK_LIMIT = 4;

  logic        clk = 1'b0;
  logic        resetn;
  logic        if_start, if_flush, if_busy, if_done;
  logic [31:0] if_addr, if_rdata;
  logic        mem_start, mem_we, mem_busy, mem_done;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;
  logic        m_start, m_we, m_done, m_busy;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic [3:0]  m_wstrb;

  int n_pass  = 0;
  int n_total = 0;

  axi_req_arbiter dut (
    .clk(clk), .resetn(resetn),
    .if_start(if_start), .if_addr(if_addr), .if_flush(if_flush),
    .if_busy(if_busy), .if_done(if_done), .if_rdata(if_rdata),
    .mem_start(mem_start), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_busy(mem_busy), .mem_done(mem_done), .mem_rdata(mem_rdata),
    .m_start(m_start), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_wstrb(m_wstrb), .m_done(m_done), .m_rdata(m_rdata), .m_busy(m_busy)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
  endtask

  task automatic check_b(input string name, input logic act, input logic exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b, want %b", name, act, exp);
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    if_start = 0; if_addr = '0; if_flush = 0;
    mem_start = 0; mem_we = 0; mem_addr = '0; mem_wdata = '0; mem_wstrb = '0;
    m_done = 0; m_rdata = '0; m_busy = 0;
  endtask

  task automatic do_reset();
    resetn = 0;
    cyc(); cyc();
    resetn = 1;
    cyc();
  endtask

  // Returns at a falling edge where m_start is high, or after the budget.
  task automatic wait_mstart(input string name, input int budget);
    int i = 0;
    while (!m_start && i < budget) begin cyc(); i++; end
    check_b($sformatf("%s_mstart_seen", name), m_start, 1'b1);
  endtask

  // Called where m_start is visible; completes after lat cycles in WAIT.
  // Returns at the falling edge where the done pulse should be visible.
  task automatic serve(input int lat, input logic [31:0] rd);
    repeat (lat) cyc();
    m_done = 1; m_rdata = rd;
    cyc();
    m_done = 0; m_rdata = '0;
  endtask

  task automatic check_all_zero(input string tag);
    check_b({tag, "_m_start"}, m_start, 1'b0);
    check_b({tag, "_if_busy"}, if_busy, 1'b0);
    check_b({tag, "_mem_busy"}, mem_busy, 1'b0);
    check_b({tag, "_if_done"}, if_done, 1'b0);
    check_b({tag, "_mem_done"}, mem_done, 1'b0);
    check_b({tag, "_m_we"}, m_we, 1'b0);
    check({tag, "_m_addr"}, m_addr, 32'h0);
    check({tag, "_m_wdata"}, m_wdata, 32'h0);
    check({tag, "_m_wstrb"}, 32'(m_wstrb), 32'h0);
    check({tag, "_if_rdata"}, if_rdata, 32'h0);
    check({tag, "_mem_rdata"}, mem_rdata, 32'h0);
  endtask

  typedef struct {
    logic        is_mem;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] rdata;
    int          lat;
    logic        exp_m_we;
    logic [31:0] exp_m_addr;
    logic [31:0] exp_m_wdata;
    logic [3:0]  exp_m_wstrb;
    logic        exp_if_done;
    logic        exp_mem_done;
    logic        chk_rdata;
    logic [31:0] exp_rdata;
  } vec_t;

  // Reference model state (transaction level).
  bit          r_pif, r_pmem, r_disc, r_if_done, r_mem_done, r_done_we;
  logic [31:0] r_if_addr, r_mem_addr, r_mem_wdata, r_if_rdata, r_mem_rdata;
  logic        r_mem_we;
  logic [3:0]  r_mem_wstrb;
  int          r_own, r_phase, r_streak;
  logic        r_m_we;
  logic [31:0] r_m_addr, r_m_wdata;
  logic [3:0]  r_m_wstrb;

  task automatic model_init();
    r_pif = 0; r_pmem = 0; r_disc = 0; r_if_done = 0; r_mem_done = 0; r_done_we = 0;
    r_if_addr = '0; r_mem_addr = '0; r_mem_wdata = '0; r_mem_we = 0; r_mem_wstrb = '0;
    r_if_rdata = '0; r_mem_rdata = '0;
    r_own = 0; r_phase = 0; r_streak = 0;
    r_m_we = 0; r_m_addr = '0; r_m_wdata = '0; r_m_wstrb = '0;
  endtask

  // Advance the model by one clock using the inputs about to be sampled.
  // r_own: 0 none, 1 IF, 2 MEM.  r_phase: 0 waiting for work, 1 start cycle, 2 on the bus.
  task automatic model_step();
    bit acc_if, acc_mem, elig_if, g_if, g_mem, fin;
    acc_if  = if_start && !(r_pif || r_own == 1);
    acc_mem = mem_start && !(r_pmem || r_own == 2);
    elig_if = r_pif && !if_flush;
    g_if = 0; g_mem = 0;
    if (r_phase == 0 && !m_busy) begin
      if (r_pmem && !(elig_if && r_streak == STREAK_LIMIT)) g_mem = 1;
      else if (elig_if) g_if = 1;
    end
    fin = (r_phase == 2) && m_done;
    r_if_done  = fin && r_own == 1 && !r_disc;
    r_mem_done = fin && r_own == 2;
    if (r_if_done) r_if_rdata = m_rdata;
    if (r_mem_done) begin r_mem_rdata = m_rdata; r_done_we = r_m_we; end
    if (g_if || !r_pif) r_streak = 0;
    else if (g_mem && r_streak < 7) r_streak++;
    if (fin) r_disc = 0;
    else if (if_flush && r_own == 1) r_disc = 1;
    if (g_if) begin
      r_own = 1; r_m_we = 0; r_m_addr = r_if_addr; r_m_wdata = '0; r_m_wstrb = '0;
    end else if (g_mem) begin
      r_own = 2; r_m_we = r_mem_we; r_m_addr = r_mem_addr;
      r_m_wdata = r_mem_wdata; r_m_wstrb = r_mem_wstrb;
    end else if (fin) begin
      r_own = 0;
    end
    if (r_phase == 0) r_phase = (g_if || g_mem) ? 1 : 0;
    else if (r_phase == 1) r_phase = 2;
    else r_phase = m_done ? 0 : 2;
    if (acc_if) begin r_pif = 1; r_if_addr = if_addr; end
    else if (if_flush || g_if) r_pif = 0;
    if (acc_mem) begin
      r_pmem = 1; r_mem_we = mem_we; r_mem_addr = mem_addr;
      r_mem_wdata = mem_wdata; r_mem_wstrb = mem_wstrb;
    end else if (g_mem) begin
      r_pmem = 0;
    end
  endtask

  initial begin
    vec_t vecs[4];
    int   mem_cnt;
    bit   saw_start;
    int   mst_cnt;

    vecs[0] = '{1'b0, 1'b0, 32'h0000_0010, 32'h0, 4'h0, 32'h2402_0005, 3,
                1'b0, 32'h0000_0010, 32'h0, 4'h0, 1'b1, 1'b0, 1'b1, 32'h2402_0005};
    vecs[1] = '{1'b1, 1'b0, 32'h0000_2000, 32'h1111_1111, 4'h0, 32'hCAFE_F00D, 1,
                1'b0, 32'h0000_2000, 32'h1111_1111, 4'h0, 1'b0, 1'b1, 1'b1, 32'hCAFE_F00D};
    vecs[2] = '{1'b1, 1'b1, 32'h0000_3004, 32'hA5A5_5A5A, 4'h3, 32'h0, 2,
                1'b1, 32'h0000_3004, 32'hA5A5_5A5A, 4'h3, 1'b0, 1'b1, 1'b0, 32'h0};
    vecs[3] = '{1'b0, 1'b0, 32'hFFFF_FFFC, 32'h0, 4'h0, 32'hFFFF_FFFF, 4,
                1'b0, 32'hFFFF_FFFC, 32'h0, 4'h0, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFFF};

    clear_inputs();
    resetn = 0;
    cyc();
    do_reset();
    check_all_zero("reset");

    // Directed single transactions.
    for (int i = 0; i < 4; i++) begin
      mem_wdata = 32'h5555_AAAA; mem_wstrb = 4'hC;
      if (vecs[i].is_mem) begin
        mem_start = 1; mem_we = vecs[i].we; mem_addr = vecs[i].addr;
        mem_wdata = vecs[i].wdata; mem_wstrb = vecs[i].wstrb;
      end else begin
        if_start = 1; if_addr = vecs[i].addr;
      end
      cyc();
      if_start = 0; mem_start = 0;
      check_b($sformatf("v%0d_busy", i), vecs[i].is_mem ? mem_busy : if_busy, 1'b1);
      check_b($sformatf("v%0d_no_early_start", i), m_start, 1'b0);
      cyc();
      check_b($sformatf("v%0d_m_start", i), m_start, 1'b1);
      check_b($sformatf("v%0d_m_we", i), m_we, vecs[i].exp_m_we);
      check($sformatf("v%0d_m_addr", i), m_addr, vecs[i].exp_m_addr);
      check($sformatf("v%0d_m_wdata", i), m_wdata, vecs[i].exp_m_wdata);
      check($sformatf("v%0d_m_wstrb", i), 32'(m_wstrb), 32'(vecs[i].exp_m_wstrb));
      serve(vecs[i].lat, vecs[i].rdata);
      check_b($sformatf("v%0d_if_done", i), if_done, vecs[i].exp_if_done);
      check_b($sformatf("v%0d_mem_done", i), mem_done, vecs[i].exp_mem_done);
      if (vecs[i].chk_rdata)
        check($sformatf("v%0d_rdata", i), vecs[i].is_mem ? mem_rdata : if_rdata, vecs[i].exp_rdata);
      check_b($sformatf("v%0d_no_restart", i), m_start, 1'b0);
      cyc();
      check_b($sformatf("v%0d_done_pulse_ends", i), if_done | mem_done, 1'b0);
      check_b($sformatf("v%0d_idle_busy", i), if_busy | mem_busy, 1'b0);
    end

    // Simultaneous IF and MEM: MEM first, IF right after MEM's done.
    if_start = 1; if_addr = 32'h4;
    mem_start = 1; mem_we = 1; mem_addr = 32'h1000; mem_wdata = 32'hDEAD_BEEF; mem_wstrb = 4'hF;
    cyc();
    if_start = 0; mem_start = 0;
    check_b("sim_both_busy", if_busy & mem_busy, 1'b1);
    cyc();
    check_b("sim_first_start", m_start, 1'b1);
    check_b("sim_first_we", m_we, 1'b1);
    check("sim_first_addr", m_addr, 32'h1000);
    check("sim_first_wdata", m_wdata, 32'hDEAD_BEEF);
    check("sim_first_wstrb", 32'(m_wstrb), 32'hF);
    serve(2, 32'h0);
    check_b("sim_mem_done", mem_done, 1'b1);
    check_b("sim_if_not_done", if_done, 1'b0);
    cyc();
    check_b("sim_second_start", m_start, 1'b1);
    check("sim_second_addr", m_addr, 32'h4);
    check_b("sim_second_we", m_we, 1'b0);
    serve(1, 32'h1234_5678);
    check_b("sim_if_done", if_done, 1'b1);
    check_b("sim_mem_not_done", mem_done, 1'b0);
    check("sim_if_rdata", if_rdata, 32'h1234_5678);
    cyc();

    // Starvation limit: MEM re-requests on each done while IF waits.
    if_start = 1; if_addr = 32'h100;
    mem_start = 1; mem_we = 0; mem_addr = 32'h8000;
    cyc();
    if_start = 0; mem_start = 0;
    mem_cnt = 0;
    for (int g = 0; g < 10; g++) begin
      wait_mstart($sformatf("starve_g%0d", g), 20);
      if (!m_start || m_addr == 32'h100) break;
      mem_cnt++;
      m_busy = 1;
      serve(1, 32'h0);
      mem_start = 1;
      cyc();
      mem_start = 0; m_busy = 0;
    end
    check("starve_mem_grants", mem_cnt, STREAK_LIMIT);
    check("starve_if_addr", m_addr, 32'h100);
    serve(1, 32'hABCD_0001);
    check_b("starve_if_done", if_done, 1'b1);
    cyc();
    wait_mstart("starve_drain", 10);
    check("starve_drain_addr", m_addr, 32'h8000);
    serve(1, 32'h0);
    cyc();

    // Flush while IF is still pending: it never reaches the bus.
    m_busy = 1;
    if_start = 1; if_addr = 32'h200;
    cyc();
    if_start = 0;
    check_b("flushp_busy", if_busy, 1'b1);
    if_flush = 1;
    cyc();
    if_flush = 0;
    check_b("flushp_busy_cleared", if_busy, 1'b0);
    m_busy = 0;
    saw_start = 0;
    repeat (5) begin cyc(); if (m_start) saw_start = 1; end
    check_b("flushp_no_start", saw_start, 1'b0);

    // Flush while IF owns the bus: completion is swallowed.
    if_start = 1; if_addr = 32'h40;
    cyc();
    if_start = 0;
    wait_mstart("flushw", 5);
    cyc();
    if_flush = 1;
    cyc();
    if_flush = 0;
    check_b("flushw_still_busy", if_busy, 1'b1);
    m_done = 1; m_rdata = 32'h7777_7777;
    cyc();
    m_done = 0; m_rdata = '0;
    check_b("flushw_no_if_done", if_done, 1'b0);
    check_b("flushw_busy_falls", if_busy, 1'b0);
    check("flushw_rdata_kept", if_rdata, 32'hABCD_0001);
    cyc();

    // Master busy holds off a pending MEM request.
    m_busy = 1;
    mem_start = 1; mem_we = 0; mem_addr = 32'h9000;
    saw_start = 0;
    for (int i = 0; i < 5; i++) begin
      cyc();
      mem_start = 0;
      if (m_start) saw_start = 1;
    end
    check_b("mbusy_held_off", saw_start, 1'b0);
    m_busy = 0;
    cyc();
    check_b("mbusy_start_after_release", m_start, 1'b1);
    check("mbusy_addr", m_addr, 32'h9000);
    serve(1, 32'h0BAD_CAFE);
    check_b("mbusy_mem_done", mem_done, 1'b1);
    check("mbusy_mem_rdata", mem_rdata, 32'h0BAD_CAFE);
    cyc();

    // Reset in WAIT, then a fresh fetch.
    if_start = 1; if_addr = 32'h60;
    cyc();
    if_start = 0;
    wait_mstart("rstw", 5);
    cyc();
    resetn = 0;
    cyc();
    check_all_zero("rstw");
    resetn = 1;
    cyc();
    if_start = 1; if_addr = 32'h80;
    cyc();
    if_start = 0;
    cyc();
    check_b("rstw_fresh_start", m_start, 1'b1);
    check("rstw_fresh_addr", m_addr, 32'h80);
    serve(2, 32'h0000_1111);
    check_b("rstw_fresh_done", if_done, 1'b1);
    check("rstw_fresh_rdata", if_rdata, 32'h0000_1111);
    cyc();

    // Randomized traffic against the model.
    clear_inputs();
    do_reset();
    model_init();
    mst_cnt = 0;
    for (int c = 0; c < 3000; c++) begin
      check_b("rnd_m_start", m_start, r_phase == 1);
      check_b("rnd_if_busy", if_busy, r_pif || r_own == 1);
      check_b("rnd_mem_busy", mem_busy, r_pmem || r_own == 2);
      check_b("rnd_if_done", if_done, r_if_done);
      check_b("rnd_mem_done", mem_done, r_mem_done);
      if (r_phase == 1) begin
        check_b("rnd_m_we", m_we, r_m_we);
        check("rnd_m_addr", m_addr, r_m_addr);
        check("rnd_m_wdata", m_wdata, r_m_wdata);
        check("rnd_m_wstrb", 32'(m_wstrb), 32'(r_m_wstrb));
      end
      if (r_if_done) check("rnd_if_rdata", if_rdata, r_if_rdata);
      if (r_mem_done && !r_done_we) check("rnd_mem_rdata", mem_rdata, r_mem_rdata);

      m_done = 0;
      if (m_start) mst_cnt = $urandom_range(1, 4);
      else if (mst_cnt > 0) begin
        mst_cnt--;
        if (mst_cnt == 0) begin m_done = 1; m_rdata = $urandom; end
      end else if ($urandom_range(0, 19) == 0) begin
        m_done = 1; m_rdata = $urandom;
      end
      m_busy    = (m_start || mst_cnt > 0) ? 1'b1 : ($urandom_range(0, 3) == 0);
      if_start  = ($urandom_range(0, 4) == 0);
      if_addr   = $urandom & 32'hFFFF_FFFC;
      if_flush  = ($urandom_range(0, 14) == 0);
      mem_start = ($urandom_range(0, 3) == 0);
      mem_we    = $urandom_range(0, 1);
      mem_addr  = $urandom;
      mem_wdata = $urandom;
      mem_wstrb = 4'($urandom_range(0, 15));
      model_step();
      cyc();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
